// File: rtl/rsflipflop_bank_if.sv
// Request/status bundle for rsflipflop_bank. The conflict_cnt signal exists only
// when RSFLIPFLOP_BANK_CONFLICT_CNT_EN is defined.
interface rsflipflop_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             conflict_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             conflict;
`ifdef RSFLIPFLOP_BANK_CONFLICT_CNT_EN
  logic [CNT_W-1:0] conflict_cnt;

  modport master (output s, r, conflict_clr,
                  input  q, rise, fall, conflict, conflict_cnt);
  modport slave  (input  s, r, conflict_clr,
                  output q, rise, fall, conflict, conflict_cnt);
`else
  modport master (output s, r, conflict_clr,
                  input  q, rise, fall, conflict);
  modport slave  (input  s, r, conflict_clr,
                  output q, rise, fall, conflict);
`endif
endinterface

// File: rtl/rsflipflop_bank.sv
// Bank of independent registered set/reset flip-flops with minimum-set-hold masking,
// edge pulses and a sticky conflict flag. Define RSFLIPFLOP_BANK_CONFLICT_CNT_EN for the counter.
module rsflipflop_bank #(
  parameter int WIDTH    = 8,
  parameter int MODE     = 0,
  parameter int MIN_HOLD = 0,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  rsflipflop_bank_if.slave   bus
);

  localparam int HOLD_W = 8;

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("rsflipflop_bank: WIDTH out of range");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("rsflipflop_bank: MODE out of range");
  end
  if (MIN_HOLD < 0 || MIN_HOLD > 255) begin : g_bad_hold
    $error("rsflipflop_bank: MIN_HOLD out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("rsflipflop_bank: CNT_W must be positive");
  end

  // Outcome of a simultaneous set and (unmasked) reset on one channel.
  function automatic logic resolve_conflict(input logic cur);
    if (MODE == 0)      return 1'b0;
    else if (MODE == 1) return 1'b1;
    else                return ~cur;
  endfunction

  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] r_eff;
  logic [WIDTH-1:0] hold_nz;
  logic [WIDTH-1:0] q_q,    q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             conflict_q, conflict_d;
  logic             any_conflict;

  assign s_in  = bus.s;
  assign r_in  = bus.r;
  assign r_eff = r_in & ~hold_nz;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s_in[i], r_eff[i]})
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        2'b11:   q_d[i] = resolve_conflict(q_q[i]);
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // Conflict is judged on the raw requests, before hold masking.
  always_comb begin
    rise_d       = q_d & ~q_q;
    fall_d       = ~q_d & q_q;
    any_conflict = |(s_in & r_in);
    conflict_d   = any_conflict | (conflict_q & ~bus.conflict_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q        <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      conflict_q <= conflict_d;
    end
  end

  if (MIN_HOLD > 0) begin : g_hold
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HOLD);

    logic [HOLD_W-1:0] hold_q [WIDTH];
    logic [HOLD_W-1:0] hold_d [WIDTH];

    always_comb begin
      hold_nz = '0;
      for (int i = 0; i < WIDTH; i++) begin
        hold_nz[i] = |hold_q[i];
      end
    end

    // Timer arms only on a genuine 0->1 of q; a repeated set does not re-arm it.
    always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
        hold_d[i] = hold_q[i];
        if (q_d[i] && !q_q[i]) begin
          hold_d[i] = HOLD_INIT;
        end else if (hold_nz[i]) begin
          hold_d[i] = hold_q[i] - HOLD_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (reset) hold_q[i] <= '0;
        else       hold_q[i] <= hold_d[i];
      end
    end
  end else begin : g_no_hold
    assign hold_nz = '0;
  end

`ifdef RSFLIPFLOP_BANK_CONFLICT_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear coinciding with a new conflict restarts the count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.conflict_clr) begin
      cnt_d = any_conflict ? CNT_W'(1) : '0;
    end else if (any_conflict) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.conflict_cnt = cnt_q;
`endif

  assign bus.q        = q_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_rsflipflop_bank.sv
// Directed vector bench for rsflipflop_bank: a shared stimulus drives five
// configurations (modes, hold lengths, narrow counter).
module tb_rsflipflop_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_drv;
  logic [3:0] s_drv;
  logic [3:0] r_drv;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rsflipflop_bank_if #(.WIDTH(4), .CNT_W(8)) if0 ();
  rsflipflop_bank_if #(.WIDTH(4), .CNT_W(8)) if1 ();
  rsflipflop_bank_if #(.WIDTH(4), .CNT_W(8)) if2 ();
  rsflipflop_bank_if #(.WIDTH(4), .CNT_W(2)) if3 ();
  rsflipflop_bank_if #(.WIDTH(4), .CNT_W(8)) if4 ();

  assign if0.s = s_drv; assign if0.r = r_drv; assign if0.conflict_clr = clr_drv;
  assign if1.s = s_drv; assign if1.r = r_drv; assign if1.conflict_clr = clr_drv;
  assign if2.s = s_drv; assign if2.r = r_drv; assign if2.conflict_clr = clr_drv;
  assign if3.s = s_drv; assign if3.r = r_drv; assign if3.conflict_clr = clr_drv;
  assign if4.s = s_drv; assign if4.r = r_drv; assign if4.conflict_clr = clr_drv;

  rsflipflop_bank #(.WIDTH(4), .MODE(0), .MIN_HOLD(2), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  rsflipflop_bank #(.WIDTH(4), .MODE(1), .MIN_HOLD(2), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  rsflipflop_bank #(.WIDTH(4), .MODE(2), .MIN_HOLD(0), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave));
  rsflipflop_bank #(.WIDTH(4), .MODE(0), .MIN_HOLD(2), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave));
  rsflipflop_bank #(.WIDTH(4), .MODE(2), .MIN_HOLD(2), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .bus(if4.slave));

  typedef struct {
    logic       rst;
    logic       clr;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       conf;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst_i, input logic clr_i, input logic [3:0] s_i, input logic [3:0] r_i);
    @(negedge clk);
    reset   = rst_i;
    clr_drv = clr_i;
    s_drv   = s_i;
    r_drv   = r_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst clr s r | q rise fall conf   (MODE 0, MIN_HOLD 2)
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'h5, 4'h0, 4'h5, 4'h5, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h5, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 4'h4, 4'h8, 4'hC, 4'h4, 4'h0, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 4'h0, 4'h8, 4'hC, 4'h0, 4'h0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 4'h0, 4'h8, 4'h4, 4'h0, 4'h8, 1'b0};

    reset   = 1'b1;
    clr_drv = 1'b0;
    s_drv   = 4'h0;
    r_drv   = 4'h0;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].s, tbl[i].r);
      chk($sformatf("v%0d q", i),    64'(if0.q),        64'(tbl[i].q));
      chk($sformatf("v%0d rise", i), 64'(if0.rise),     64'(tbl[i].rise));
      chk($sformatf("v%0d fall", i), 64'(if0.fall),     64'(tbl[i].fall));
      chk($sformatf("v%0d conf", i), 64'(if0.conflict), 64'(tbl[i].conf));
    end

    // Held conflict on channel 1 across all mode/hold variants.
    step(1'b1, 1'b0, 4'h0, 4'h0);
    begin
      logic [3:0] e_q1 [5];
      logic [3:0] e_q2 [5];
      logic [3:0] e_q4 [5];
      e_q1 = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
      e_q2 = '{4'h2, 4'h0, 4'h2, 4'h0, 4'h2};
      e_q4 = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h2};
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 1'b0, 4'h2, 4'h2);
        chk($sformatf("c%0d mode0 q", k),       64'(if0.q),        64'(4'h0));
        chk($sformatf("c%0d mode1 q", k),       64'(if1.q),        64'(e_q1[k]));
        chk($sformatf("c%0d toggle q", k),      64'(if2.q),        64'(e_q2[k]));
        chk($sformatf("c%0d toggle hold q", k), 64'(if4.q),        64'(e_q4[k]));
        chk($sformatf("c%0d conflict", k),      64'(if0.conflict), 64'(1'b1));
        chk($sformatf("c%0d toggle fall", k),   64'(if2.fall),     64'((k % 2 == 1) ? 4'h2 : 4'h0));
        chk($sformatf("c%0d toggle rise", k),   64'(if2.rise),     64'((k % 2 == 0) ? 4'h2 : 4'h0));
`ifdef RSFLIPFLOP_BANK_CONFLICT_CNT_EN
        chk($sformatf("c%0d cnt8", k), 64'(if0.conflict_cnt), 64'(k + 1));
        chk($sformatf("c%0d cnt2", k), 64'(if3.conflict_cnt), 64'((k + 1 > 3) ? 3 : k + 1));
`endif
      end
    end

    step(1'b0, 1'b1, 4'h0, 4'h0);
    chk("clr conflict", 64'(if0.conflict), 64'(1'b0));
`ifdef RSFLIPFLOP_BANK_CONFLICT_CNT_EN
    chk("clr cnt8", 64'(if0.conflict_cnt), 64'(0));
    chk("clr cnt2", 64'(if3.conflict_cnt), 64'(0));
`endif

    step(1'b0, 1'b1, 4'h2, 4'h2);
    chk("clr+new conflict", 64'(if0.conflict), 64'(1'b1));
`ifdef RSFLIPFLOP_BANK_CONFLICT_CNT_EN
    chk("clr+new cnt8", 64'(if0.conflict_cnt), 64'(1));
    chk("clr+new cnt2", 64'(if3.conflict_cnt), 64'(1));
`endif

    step(1'b0, 1'b0, 4'h0, 4'h0);
    chk("sticky conflict", 64'(if0.conflict), 64'(1'b1));
    chk("mode1 q before reset", 64'(if1.q), 64'(4'h2));

    step(1'b1, 1'b1, 4'hF, 4'h0);
    chk("rst mode1 q",    64'(if1.q),        64'(4'h0));
    chk("rst mode1 fall", 64'(if1.fall),     64'(4'h0));
    chk("rst mode1 rise", 64'(if1.rise),     64'(4'h0));
    chk("rst conflict",   64'(if0.conflict), 64'(1'b0));
`ifdef RSFLIPFLOP_BANK_CONFLICT_CNT_EN
    chk("rst cnt8", 64'(if0.conflict_cnt), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
